// File: rtl/i2s_rx_frame_buffer.sv
// I2S receive pairer: joins left/right 24-bit samples into 16-bit stereo frames and queues them in a FWFT FIFO.
// Optional macro I2S_RX_ROUND_SAT_EN selects round-and-saturate conversion instead of truncation.
module i2s_rx_frame_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     lmmi_clk_i,
    input  logic                     reset_n_i,
    input  logic [31:0]              sample_dat_i,
    input  logic                     sample_wr_i,
    input  logic                     ws_i,
    output logic [15:0]              frame_l_o,
    output logic [15:0]              frame_r_o,
    output logic                     frame_valid_o,
    input  logic                     frame_ready_i,
    output logic [$clog2(DEPTH):0]   fifo_level_o,
    output logic                     overflow_o,
    output logic                     align_err_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic {
        WAIT_L = 1'b0,
        WAIT_R = 1'b1
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic               latch_left;
    logic               push_req;
    logic               align_set;

    logic [15:0]        conv_sample;
    logic [15:0]        left_reg;
    logic [31:0]        mem_reg [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [LVL_W-1:0]   level_reg;
    logic               overflow_reg;
    logic               align_err_reg;
    logic               fifo_full;
    logic               do_push;
    logic               do_pop;
    logic [31:0]        head_frame;
    logic               unused_bits;

`ifdef I2S_RX_ROUND_SAT_EN
    logic signed [24:0] rounded;
    logic signed [16:0] shifted;

    // Round half-up at bit 8, then clamp; positive full-scale rounds past 0x7FFF.
    assign rounded = $signed({sample_dat_i[23], sample_dat_i[23:0]}) + 25'sd128;
    assign shifted = rounded[24:8];

    always_comb begin
        conv_sample = shifted[15:0];
        if (shifted > 17'sd32767) begin
            conv_sample = 16'h7FFF;
        end else if (shifted < -17'sd32768) begin
            conv_sample = 16'h8000;
        end
    end

    assign unused_bits = &{1'b0, sample_dat_i[31:24], rounded[7:0]};
`else
    assign conv_sample = sample_dat_i[23:8];
    assign unused_bits = &{1'b0, sample_dat_i[31:24], sample_dat_i[7:0]};
`endif

    always_ff @(posedge lmmi_clk_i) begin
        if (!reset_n_i) begin
            state_reg <= WAIT_L;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (sample_wr_i) begin
            case (state_reg)
                WAIT_L:  if (!ws_i) state_next = WAIT_R;
                WAIT_R:  if (ws_i)  state_next = WAIT_L;
                default: state_next = WAIT_L;
            endcase
        end
    end

    // A second left while waiting for right replaces the held left.
    always_comb begin
        latch_left = 1'b0;
        push_req   = 1'b0;
        align_set  = 1'b0;
        if (sample_wr_i) begin
            case (state_reg)
                WAIT_L: begin
                    if (!ws_i) begin
                        latch_left = 1'b1;
                    end else begin
                        align_set  = 1'b1;
                    end
                end
                WAIT_R: begin
                    if (ws_i) begin
                        push_req   = 1'b1;
                    end else begin
                        latch_left = 1'b1;
                        align_set  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign fifo_full = (level_reg == LVL_W'(DEPTH));
    assign do_pop    = reset_n_i && frame_valid_o && frame_ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push   = reset_n_i && push_req && (!fifo_full || do_pop);

    always_ff @(posedge lmmi_clk_i) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= {left_reg, conv_sample};
        end
    end

    always_ff @(posedge lmmi_clk_i) begin
        if (!reset_n_i) begin
            left_reg      <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            overflow_reg  <= 1'b0;
            align_err_reg <= 1'b0;
        end else begin
            if (latch_left) begin
                left_reg <= conv_sample;
            end
            if (align_set) begin
                align_err_reg <= 1'b1;
            end
            if (push_req && !do_push) begin
                overflow_reg <= 1'b1;
            end
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

    assign head_frame    = mem_reg[rd_ptr_reg];
    assign frame_valid_o = (level_reg != '0);
    assign frame_l_o     = frame_valid_o ? head_frame[31:16] : 16'h0000;
    assign frame_r_o     = frame_valid_o ? head_frame[15:0]  : 16'h0000;
    assign fifo_level_o  = level_reg;
    assign overflow_o    = overflow_reg;
    assign align_err_o   = align_err_reg;

endmodule

// File: tb/tb_i2s_rx_frame_buffer.sv
// Scoreboard bench for i2s_rx_frame_buffer: expected frames are queued when a pair completes
// and compared when the DUT hands the head frame downstream.
module tb_i2s_rx_frame_buffer;

    localparam int DEPTH = 4;

`ifdef I2S_RX_ROUND_SAT_EN
    localparam logic [15:0] T1_R_EXP = 16'hFEDD;
`else
    localparam logic [15:0] T1_R_EXP = 16'hFEDC;
`endif

    logic        clk;
    logic        reset_n;
    logic [31:0] sample_dat;
    logic        sample_wr;
    logic        ws;
    logic [15:0] frame_l;
    logic [15:0] frame_r;
    logic        frame_valid;
    logic        frame_ready;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic        align_err;

    logic [31:0] exp_q[$];
    int          total_cnt = 0;
    int          bad_cnt   = 0;

    i2s_rx_frame_buffer #(.DEPTH(DEPTH)) dut (
        .lmmi_clk_i    (clk),
        .reset_n_i     (reset_n),
        .sample_dat_i  (sample_dat),
        .sample_wr_i   (sample_wr),
        .ws_i          (ws),
        .frame_l_o     (frame_l),
        .frame_r_o     (frame_r),
        .frame_valid_o (frame_valid),
        .frame_ready_i (frame_ready),
        .fifo_level_o  (fifo_level),
        .overflow_o    (overflow),
        .align_err_o   (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total_cnt++;
        if (got !== expv) begin
            bad_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, expv);
        end else begin
            $display("ok   %s got=%h", tag, got);
        end
    endtask

    // One sample strobe; called at posedge+1, returns at posedge+1.
    task automatic send(input logic ws_v, input logic [31:0] dat);
        sample_wr  = 1'b1;
        ws         = ws_v;
        sample_dat = dat;
        @(posedge clk); #1;
        sample_wr  = 1'b0;
        ws         = 1'b0;
        sample_dat = 32'h0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        idle(n);
        reset_n = 1'b1;
    endtask

    // Monitor: a frame is consumed whenever valid and ready are both high at an edge.
    always @(negedge clk) begin
        if (reset_n && frame_valid && frame_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_extra_frame", {31'd0, frame_valid}, 32'd0);
            end else begin
                chk("sb_frame", {frame_l, frame_r}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n     = 1'b0;
        sample_dat  = 32'h0;
        sample_wr   = 1'b0;
        ws          = 1'b0;
        frame_ready = 1'b0;
        @(posedge clk); #1;
        // Strobes during reset must be ignored.
        sample_wr = 1'b1; ws = 1'b0; sample_dat = 32'h00AA5500;
        frame_ready = 1'b1;
        idle(2);
        sample_wr = 1'b0; frame_ready = 1'b0;
        reset_n = 1'b1;

        chk("rst_valid", {31'd0, frame_valid}, 32'd0);
        chk("rst_level", {29'd0, fifo_level}, 32'd0);
        chk("rst_flags", {30'd0, overflow, align_err}, 32'd0);
        chk("rst_data",  {frame_l, frame_r}, 32'd0);

        // Basic pair with ready high.
        frame_ready = 1'b1;
        send(1'b0, 32'h00123456);
        chk("t1_no_valid_after_l", {31'd0, frame_valid}, 32'd0);
        exp_q.push_back({16'h1234, T1_R_EXP});
        send(1'b1, 32'h00FEDCBA);
        chk("t1_valid", {31'd0, frame_valid}, 32'd1);
        idle(2);
        chk("t1_level", {29'd0, fifo_level}, 32'd0);
        chk("t1_idle_data", {frame_l, frame_r}, 32'd0);

        // Full-scale extremes, upper byte ignored.
        exp_q.push_back({16'h7FFF, 16'h8000});
        send(1'b0, 32'hA57FFFC0);
        send(1'b1, 32'h5A800000);
        idle(2);
        chk("t2_flags", {30'd0, overflow, align_err}, 32'd0);

        // Right first after reset is dropped.
        do_reset(1);
        send(1'b1, 32'h00555500);
        chk("t3_align", {31'd0, align_err}, 32'd1);
        chk("t3_level", {29'd0, fifo_level}, 32'd0);
        exp_q.push_back({16'h0100, 16'h0200});
        send(1'b0, 32'h00010000);
        send(1'b1, 32'h00020000);
        idle(2);

        // Overflow: five frames into a four-deep FIFO with ready low.
        do_reset(1);
        frame_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k <= DEPTH) exp_q.push_back({8'(k), 8'h00, 8'(8'h80 + k), 8'h00});
            send(1'b0, {8'h00, 8'(k), 16'h0000});
            send(1'b1, {8'h00, 8'(8'h80 + k), 16'h0000});
        end
        chk("t4_level_full", {29'd0, fifo_level}, 32'd4);
        chk("t4_overflow", {31'd0, overflow}, 32'd1);
        chk("t4_head", {frame_l, frame_r}, 32'h01008100);
        frame_ready = 1'b1;
        idle(6);
        chk("t4_level_empty", {29'd0, fifo_level}, 32'd0);
        chk("t4_sb_empty", exp_q.size(), 32'd0);
        chk("t4_overflow_sticky", {31'd0, overflow}, 32'd1);

        // Push while full with a simultaneous pop.
        frame_ready = 1'b0;
        do_reset(1);
        for (int k = 1; k <= DEPTH; k++) begin
            exp_q.push_back({8'(8'h10 + k), 8'h00, 8'(8'h20 + k), 8'h00});
            send(1'b0, {8'h00, 8'(8'h10 + k), 16'h0000});
            send(1'b1, {8'h00, 8'(8'h20 + k), 16'h0000});
        end
        send(1'b0, 32'h00150000);
        chk("t5_level_before", {29'd0, fifo_level}, 32'd4);
        exp_q.push_back({16'h1500, 16'h2500});
        frame_ready = 1'b1;
        send(1'b1, 32'h00250000);
        frame_ready = 1'b0;
        chk("t5_level_kept", {29'd0, fifo_level}, 32'd4);
        chk("t5_no_overflow", {31'd0, overflow}, 32'd0);
        frame_ready = 1'b1;
        idle(6);
        chk("t5_sb_empty", exp_q.size(), 32'd0);
        frame_ready = 1'b0;

        // Reset between left and right discards the held left.
        do_reset(1);
        send(1'b0, 32'h00112233);
        do_reset(1);
        send(1'b1, 32'h00445566);
        idle(2);
        chk("t6_valid", {31'd0, frame_valid}, 32'd0);
        chk("t6_align", {31'd0, align_err}, 32'd1);
        chk("t6_level", {29'd0, fifo_level}, 32'd0);
        chk("t6_data", {frame_l, frame_r}, 32'd0);

        chk("final_sb_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
